// File: rtl/mem_bank_pkg.sv
// mem_bank shared types
// FSM states, op codes and index-width helper
package mem_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_decode.sv
// mem_bank address decoder
// Range/alignment check and word index
module mem_bank_decode
  import mem_bank_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NREGS  = 8,
  parameter logic [ADDR_W-1:0] BASE = 32'h1000_0000
) (
  input  logic [ADDR_W-1:0]        Dir_Mem,
  output logic                     valid,
  output logic [idx_w(NREGS)-1:0]  idx
);

  localparam int IDX_W = idx_w(NREGS);

  logic [ADDR_W-1:0] w_off;

  assign w_off = Dir_Mem - BASE;

  // BASE is aligned to the bank size, so a zero
  // offset above the index bits means in range
  assign valid = (Dir_Mem >= BASE)
              && (w_off[ADDR_W-1:IDX_W+2] == '0)
              && (w_off[1:0] == 2'b00);

  assign idx = w_off[IDX_W+1:2];

endmodule

// File: rtl/mem_bank.sv
// mem_bank top
// Strobed word bank with ack, error and byte enables
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NREGS  = 8,
  parameter logic [ADDR_W-1:0] BASE   = 32'h1000_0000,
  parameter logic [DATA_W-1:0] DEF_RD = 32'h0000_000F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Mem_rd,
  input  logic                Mem_wr,
  input  logic [DATA_W/8-1:0] Mem_be,
  input  logic [ADDR_W-1:0]   Dir_Mem,
  input  logic [DATA_W-1:0]   Dato_Mem_in,
  output logic [DATA_W-1:0]   Dato_Mem_out,
  output logic                Mem_ack,
  output logic                Mem_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = idx_w(NREGS);

  state_t            r_state;
  state_t            w_state_nxt;
  op_t               r_op;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [NREGS];
  logic [DATA_W-1:0] r_dout;
  logic              r_ack;
  logic              r_err;

  logic              w_req;
  logic              w_bus_idle;
  logic              w_latch;
  logic              w_exec;
  logic              w_dec_valid;
  logic [IDX_W-1:0]  w_dec_idx;

  assign w_req      = ~Mem_rd | ~Mem_wr;
  assign w_bus_idle = Mem_rd & Mem_wr;

  mem_bank_decode #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS),
    .BASE   (BASE)
  ) u_decode (
    .Dir_Mem (Dir_Mem),
    .valid   (w_dec_valid),
    .idx     (w_dec_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_exec      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_exec      = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_bus_idle) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the request at the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_RD;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_op    <= Mem_rd ? OP_WR : OP_RD;
      r_idx   <= w_dec_idx;
      r_valid <= w_dec_valid;
      r_be    <= Mem_be;
      r_wdata <= Dato_Mem_in;
    end
  end

  // Byte-enabled storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_mem[i] <= '0;
    end else if (w_exec && r_op == OP_WR && r_valid) begin
      for (int k = 0; k < NB; k++)
        if (r_be[k])
          r_mem[r_idx][k*8 +: 8] <= r_wdata[k*8 +: 8];
    end
  end

  // Registered ack, error and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_ack <= w_exec;
      r_err <= w_exec & ~r_valid;
      if (w_exec && r_op == OP_RD)
        r_dout <= r_valid ? r_mem[r_idx] : DEF_RD;
    end
  end

  assign Dato_Mem_out = r_dout;
  assign Mem_ack      = r_ack;
  assign Mem_err      = r_err;

endmodule

// File: tb/tb_mem_bank.sv
// mem_bank testbench
// Random and directed accesses against an array model
module tb_mem_bank;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] DEFR = 32'h0000_000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_rd = 1'b1;
  logic        Mem_wr = 1'b1;
  logic [3:0]  Mem_be = '0;
  logic [31:0] Dir_Mem = '0;
  logic [31:0] Dato_Mem_in = '0;
  logic [31:0] Dato_Mem_out;
  logic        Mem_ack;
  logic        Mem_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [8];
  logic [31:0] mdl_dout;

  always #5 clk = ~clk;

  mem_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Mem_rd       (Mem_rd),
    .Mem_wr       (Mem_wr),
    .Mem_be       (Mem_be),
    .Dir_Mem      (Dir_Mem),
    .Dato_Mem_in  (Dato_Mem_in),
    .Dato_Mem_out (Dato_Mem_out),
    .Mem_ack      (Mem_ack),
    .Mem_err      (Mem_err)
  );

  function automatic bit m_valid(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32) && (a[1:0] == 2'b00);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mdl_dout = '0;
  endtask

  task automatic m_apply(input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output logic exp_err);
    bit ok;
    int unsigned ix;
    ok = m_valid(a);
    exp_err = !ok;
    ix = 0;
    if (ok) ix = (a - BASE) / 4;
    if (rd) begin
      mdl_dout = ok ? mdl[ix] : DEFR;
    end else if (ok) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mdl[ix][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic bus_op(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold,
                        output int acks, output int pos,
                        output logic [31:0] dout, output logic err);
    acks = 0;
    pos  = -1;
    dout = 'x;
    err  = 1'bx;
    @(posedge clk); #1;
    Mem_rd = ~rd;
    Mem_wr = ~wr;
    Dir_Mem = a;
    Dato_Mem_in = d;
    Mem_be = be;
    @(posedge clk); #1;
    Dir_Mem = $urandom;
    Dato_Mem_in = $urandom;
    Mem_be = 4'($urandom);
    for (int c = 1; c <= 4 + hold; c++) begin
      @(posedge clk);
      if (c == 1 + hold) begin
        #1;
        Mem_rd = 1'b1;
        Mem_wr = 1'b1;
      end
      @(negedge clk);
      if (Mem_ack === 1'b1) begin
        acks++;
        if (pos < 0) begin
          pos  = c;
          dout = Dato_Mem_out;
          err  = Mem_err;
        end
      end
    end
  endtask

  task automatic run_op(input string nm, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold);
    int acks, pos;
    logic [31:0] dout;
    logic err, eerr;
    bus_op(rd, wr, a, d, be, hold, acks, pos, dout, err);
    m_apply(rd, a, d, be, eerr);
    checks++;
    if (acks !== 1 || pos !== 1) begin
      errors++;
      $display("FAIL %s ack: count=%0d pos=%0d want count=1 pos=1",
               nm, acks, pos);
    end
    checks++;
    if (err !== eerr) begin
      errors++;
      $display("FAIL %s err: got %b want %b a=%h", nm, err, eerr, a);
    end
    checks++;
    if (Dato_Mem_out !== mdl_dout || (rd && dout !== mdl_dout)) begin
      errors++;
      $display("FAIL %s dout: got %h/%h want %h a=%h",
               nm, dout, Dato_Mem_out, mdl_dout, a);
    end
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < 8; i++)
      run_op(nm, 1'b1, 1'b0, BASE + 32'(4 * i), '0, '0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Mem_ack !== 1'b0 || Mem_err !== 1'b0 || Dato_Mem_out !== '0) begin
      errors++;
      $display("FAIL reset_in: ack=%b err=%b dout=%h want 0 0 0",
               Mem_ack, Mem_err, Dato_Mem_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (Mem_ack !== 1'b0 || Dato_Mem_out !== '0) begin
      errors++;
      $display("FAIL reset_out: ack=%b dout=%h want 0 0",
               Mem_ack, Dato_Mem_out);
    end
    check_all("reset_rd");
  endtask

  task automatic test_full();
    run_op("full_wr", 1'b0, 1'b1, BASE + 4, 32'hDEADBEEF, 4'hF, 0);
    run_op("full_rd", 1'b1, 1'b0, BASE + 4, '0, '0, 0);
    checks++;
    if (Dato_Mem_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL full_val: got %h want deadbeef", Dato_Mem_out);
    end
  endtask

  task automatic test_byte_en();
    run_op("be_wr", 1'b0, 1'b1, BASE + 4, 32'h11223344, 4'b0101, 0);
    run_op("be_rd", 1'b1, 1'b0, BASE + 4, '0, '0, 0);
    checks++;
    if (Dato_Mem_out !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL be_val: got %h want de22be44", Dato_Mem_out);
    end
    run_op("be_zero", 1'b0, 1'b1, BASE + 4, 32'hFFFFFFFF, 4'b0000, 0);
    run_op("be_zero_rd", 1'b1, 1'b0, BASE + 4, '0, '0, 0);
  endtask

  task automatic test_invalid();
    run_op("inv_hi", 1'b1, 1'b0, BASE + 32'h20, '0, '0, 0);
    checks++;
    if (Dato_Mem_out !== DEFR) begin
      errors++;
      $display("FAIL inv_hi_val: got %h want %h", Dato_Mem_out, DEFR);
    end
    run_op("inv_mis", 1'b1, 1'b0, BASE + 2, '0, '0, 0);
    run_op("inv_lo", 1'b1, 1'b0, BASE - 4, '0, '0, 0);
    run_op("inv_wr", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0);
    run_op("inv_wr_hi", 1'b0, 1'b1, BASE + 32, 32'h12345678, 4'hF, 0);
    check_all("inv_scan");
  endtask

  task automatic test_both_long();
    run_op("pre_wr0", 1'b0, 1'b1, BASE, 32'h0BADF00D, 4'hF, 0);
    run_op("both", 1'b1, 1'b1, BASE, 32'h77777777, 4'hF, 0);
    run_op("both_rd", 1'b1, 1'b0, BASE, '0, '0, 0);
    run_op("long_rd", 1'b1, 1'b0, BASE, '0, '0, 9);
    run_op("long_wr", 1'b0, 1'b1, BASE + 28, 32'h600DCAFE, 4'hF, 9);
    run_op("long_chk", 1'b1, 1'b0, BASE + 28, '0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [31:0] d;
    d = $urandom;
    @(posedge clk); #1;
    Mem_wr = 1'b0;
    Dir_Mem = BASE + 8;
    Dato_Mem_in = d;
    Mem_be = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    Mem_wr = 1'b1;
    m_apply(1'b0, BASE + 8, d, 4'hF, e);
    @(negedge clk);
    checks++;
    if (Mem_ack !== 1'b1 || Mem_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wr: ack=%b err=%b want 1 0", Mem_ack, Mem_err);
    end
    @(posedge clk); #1;
    Mem_rd = 1'b0;
    Dir_Mem = BASE + 8;
    @(negedge clk);
    checks++;
    if (Mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: ack=%b want 0", Mem_ack);
    end
    @(posedge clk);
    @(posedge clk); #1;
    Mem_rd = 1'b1;
    m_apply(1'b1, BASE + 8, '0, '0, e);
    @(negedge clk);
    checks++;
    if (Mem_ack !== 1'b1 || Mem_err !== 1'b0 || Dato_Mem_out !== mdl_dout) begin
      errors++;
      $display("FAIL b2b_rd: ack=%b err=%b dout=%h want 1 0 %h",
               Mem_ack, Mem_err, Dato_Mem_out, mdl_dout);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0] be;
    int k;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: a = BASE + 4 * $urandom_range(0, 7);
        3:       a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
        default: a = $urandom_range(0, 1)
                   ? BASE + 32 + 4 * $urandom_range(0, 7)
                   : BASE - 4 * $urandom_range(1, 4);
      endcase
      d  = $urandom;
      be = 4'($urandom);
      k  = $urandom_range(0, 2);
      run_op("rand", k != 1, k != 0, a, d, be, $urandom_range(0, 2));
    end
    check_all("rand_scan");
  endtask

  task automatic test_reset_mid();
    int acks;
    run_op("mid_pre_wr", 1'b0, 1'b1, BASE + 12, 32'hA5A55A5A, 4'hF, 0);
    run_op("mid_pre_rd", 1'b1, 1'b0, BASE + 12, '0, '0, 0);
    @(posedge clk); #1;
    Mem_wr = 1'b0;
    Dir_Mem = BASE + 12;
    Dato_Mem_in = 32'h13572468;
    Mem_be = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (Mem_ack !== 1'b0 || Mem_err !== 1'b0 || Dato_Mem_out !== '0) begin
      errors++;
      $display("FAIL mid_async: ack=%b err=%b dout=%h want 0 0 0",
               Mem_ack, Mem_err, Dato_Mem_out);
    end
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (Mem_ack !== 1'b0) acks++;
    end
    Mem_wr = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (Mem_ack !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL mid_ack: acks=%0d want 0", acks);
    end
    run_op("mid_rd", 1'b1, 1'b0, BASE + 12, '0, '0, 0);
    checks++;
    if (Dato_Mem_out !== '0) begin
      errors++;
      $display("FAIL mid_word: got %h want 0", Dato_Mem_out);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_byte_en();
    test_invalid();
    test_both_long();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
